alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: TAG_W, default 4, width of request/response tag.
REQ-002 SHALL have ports, N = 0,1 per requester (clock and reset first):
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- reqN_valid  in  1  requester N presents an operation
- reqN_ready  out  1  operation accepted this cycle when valid&ready
- reqN_op  in  4  ALU control code
- reqN_a, reqN_b  in  32  operands d1, d2
- reqN_tag  in  TAG_W  opaque ID returned with result
- rspN_valid  out  1  result held for requester N
- rspN_ready  in  1  requester N consumes result when valid&ready
- rspN_result  out  32  ALU result
- rspN_tag  out  TAG_W  tag of the accepted request
- rspN_err  out  1  op code was unsupported
REQ-003 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 SHALL share one ALU instance between both requesters; at most one request accepted per cycle.
REQ-005 SHALL consider requester N eligible when reqN_valid=1 and its response slot is empty or drains this cycle (rspN_valid&rspN_ready).
- Single eligible requester: granted.
- Both eligible: grant the requester indicated by round-robin pointer.
REQ-006 SHALL drive reqN_ready=1 only for the granted requester; combinational from valid, pointer, slot state, rspN_ready.
REQ-007 SHALL move the pointer to the other requester after any grant; pointer unchanged on idle cycles.
REQ-008 SHALL capture result, tag, err into requester N's slot on acceptance; rspN_valid=1 the next cycle (latency 1).
REQ-009 SHALL hold rspN_result/tag/err and rspN_valid stable until rspN_ready=1; the two slots are independent.
REQ-010 SHALL permit accept and drain of the same slot in one cycle (back-to-back throughput 1/cycle per requester when other idle).
REQ-011 SHALL support codes 0000 ADD, 0001 SLL, 0010 SLT (signed), 0011 SLTU, 0100 XOR, 0101 SRL, 0110 OR, 0111 AND, 1000 SUB, 1101 SRA (arithmetic); shift amount = b[4:0]; ADD/SUB wrap modulo 2^32.
REQ-012 SHALL, for any other code, store result 32'h0 and err=1, still accept and respond (no X on outputs).
REQ-013 SHALL ignore op/a/b/tag when not accepted; no partial capture.

Reset
REQ-014 SHALL on rst_n=0 immediately force rspN_valid=0, rspN_result=0, rspN_tag=0, rspN_err=0, pointer=requester 0.
REQ-015 SHALL discard any held result on reset mid-operation; no response emitted for it after release.
REQ-016 SHALL drive reqN_ready=0 while rst_n=0; first acceptance no earlier than first rising edge with rst_n=1.

Structure
REQ-017 SHALL place ALU op-code localparams (ALU_ADD..ALU_SRA) and a supported-op check function in shared package alu_pkg.
REQ-018 SHALL instantiate the existing ALU module as its only sub-module; ALU fixed so SLT compares signed and SRA shifts arithmetically.
REQ-019 SHALL implement per-requester slot as one registered struct {valid, result, tag, err}, no FIFO.

Verification
REQ-020 Single: req0 ADD a=7 b=5 tag=3, rsp0_ready=1 -> next cycle rsp0_valid=1, result=12, tag=3, err=0.
REQ-021 Contention: both valid every cycle, rsp ready=1, after reset -> grants 0,1,0,1; req1 SUB 5-7 gives 32'hFFFFFFFE.
REQ-022 Backpressure: rsp0_ready=0 with slot full, req0 valid -> req0_ready=0, rsp0 values stable; req1 still granted every cycle.
REQ-023 Ops: SLT a=32'hFFFFFFFF b=1 -> 1; SLTU same -> 0; SRA a=32'h80000000 b=33 -> 32'hC0000000.
REQ-024 Illegal: op 1010 tag=9 -> result 0, err=1, tag=9; next legal op err=0.
REQ-025 Reset: rst_n low between accept and drain -> rsp0_valid falls asynchronously; no response after release; pointer=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU op-code definitions and helpers for the ALU and the requester arbiter.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned ALU_DW   = 32;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'b1101;

  typedef enum logic {
    RR_REQ0 = 1'b0,
    RR_REQ1 = 1'b1
  } rr_ptr_t;

  function automatic logic alu_op_supported(input logic [ALU_OP_W-1:0] op);
    logic ok;
    case (op)
      ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_OR, ALU_AND, ALU_SUB, ALU_SRA: ok = 1'b1;
      default:                                    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; unsupported codes produce zero.
module alu
  import alu_pkg::*;
(
  input  logic [ALU_OP_W-1:0] op,
  input  logic [ALU_DW-1:0]   d1,
  input  logic [ALU_DW-1:0]   d2,
  output logic [ALU_DW-1:0]   result
);

  logic [4:0] shamt;
  assign shamt = d2[4:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = d1 + d2;
      ALU_SLL:  result = d1 << shamt;
      ALU_SLT:  result = {{(ALU_DW-1){1'b0}}, ($signed(d1) < $signed(d2))};
      ALU_SLTU: result = {{(ALU_DW-1){1'b0}}, (d1 < d2)};
      ALU_XOR:  result = d1 ^ d2;
      ALU_SRL:  result = d1 >> shamt;
      ALU_OR:   result = d1 | d2;
      ALU_AND:  result = d1 & d2;
      ALU_SUB:  result = d1 - d2;
      ALU_SRA:  result = $signed(d1) >>> shamt;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one ALU; each requester owns a
// single registered response slot.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_result,
  output logic [TAG_W-1:0] rsp0_tag,
  output logic             rsp0_err,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_result,
  output logic [TAG_W-1:0] rsp1_tag,
  output logic             rsp1_err
);

  typedef struct packed {
    logic             valid;
    logic [31:0]      result;
    logic [TAG_W-1:0] tag;
    logic             err;
  } slot_t;

  slot_t   slot0_q, slot0_d, slot1_q, slot1_d;
  rr_ptr_t ptr_q, ptr_d;

  logic        elig0, elig1, grant0, grant1;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_err;

  // A full slot that is draining this cycle can accept again (1/cycle throughput).
  assign elig0  = req0_valid & (~slot0_q.valid | rsp0_ready);
  assign elig1  = req1_valid & (~slot1_q.valid | rsp1_ready);
  assign grant0 = rst_n & elig0 & (~elig1 | (ptr_q == RR_REQ0));
  assign grant1 = rst_n & elig1 & (~elig0 | (ptr_q == RR_REQ1));

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign alu_op  = grant1 ? req1_op : req0_op;
  assign alu_a   = grant1 ? req1_a  : req0_a;
  assign alu_b   = grant1 ? req1_b  : req0_b;
  assign alu_err = ~alu_op_supported(alu_op);

  alu u_alu (
    .op     (alu_op),
    .d1     (alu_a),
    .d2     (alu_b),
    .result (alu_result)
  );

  always_comb begin
    slot0_d = slot0_q;
    if (slot0_q.valid & rsp0_ready) slot0_d.valid = 1'b0;
    if (grant0) slot0_d = '{valid: 1'b1, result: alu_result, tag: req0_tag, err: alu_err};

    slot1_d = slot1_q;
    if (slot1_q.valid & rsp1_ready) slot1_d.valid = 1'b0;
    if (grant1) slot1_d = '{valid: 1'b1, result: alu_result, tag: req1_tag, err: alu_err};

    ptr_d = ptr_q;
    if (grant0)      ptr_d = RR_REQ1;
    else if (grant1) ptr_d = RR_REQ0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      ptr_q   <= RR_REQ0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      ptr_q   <= ptr_d;
    end
  end

  assign rsp0_valid  = slot0_q.valid;
  assign rsp0_result = slot0_q.result;
  assign rsp0_tag    = slot0_q.tag;
  assign rsp0_err    = slot0_q.err;
  assign rsp1_valid  = slot1_q.valid;
  assign rsp1_result = slot1_q.result;
  assign rsp1_tag    = slot1_q.tag;
  assign rsp1_err    = slot1_q.err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter.
module tb_alu_arbiter;

  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_err;
  logic [3:0]       req0_op;
  logic [31:0]      req0_a, req0_b, rsp0_result;
  logic [TAG_W-1:0] req0_tag, rsp0_tag;
  logic             req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_err;
  logic [3:0]       req1_op;
  logic [31:0]      req1_a, req1_b, rsp1_result;
  logic [TAG_W-1:0] req1_tag, rsp1_tag;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_tag(rsp0_tag), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_tag(rsp1_tag), .rsp1_err(rsp1_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_op = 4'b0000; req0_a = '0; req0_b = '0; req0_tag = '0;
    req1_valid = 0; req1_op = 4'b0000; req1_a = '0; req1_b = '0; req1_tag = '0;
    rsp0_ready = 1; rsp1_ready = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    req0_valid = 1; req1_valid = 1;
    rst_n = 0;
    #1;
    tests++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      fails++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
    end
    step();
    tests++;
    if (rsp0_valid !== 1'b0 || rsp0_result !== 32'h0 || rsp0_tag !== 4'h0 || rsp0_err !== 1'b0) begin
      fails++; $display("FAIL reset_rsp0: got v=%b r=%h t=%h e=%b want 0", rsp0_valid, rsp0_result, rsp0_tag, rsp0_err);
    end
    tests++;
    if (rsp1_valid !== 1'b0 || rsp1_result !== 32'h0 || rsp1_tag !== 4'h0 || rsp1_err !== 1'b0) begin
      fails++; $display("FAIL reset_rsp1: got v=%b r=%h t=%h e=%b want 0", rsp1_valid, rsp1_result, rsp1_tag, rsp1_err);
    end
    idle_inputs();
    rst_n = 1;
    step();
  endtask

  task automatic test_single();
    req0_valid = 1; req0_op = 4'b0000; req0_a = 7; req0_b = 5; req0_tag = 3;
    rsp0_ready = 1;
    #1;
    tests++;
    if (req0_ready !== 1'b1) begin
      fails++; $display("FAIL single_ready: got %b want 1", req0_ready);
    end
    step();
    req0_valid = 0;
    tests++;
    if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd12 || rsp0_tag !== 4'd3 || rsp0_err !== 1'b0) begin
      fails++; $display("FAIL single_rsp: got v=%b r=%0d t=%0d e=%b want v=1 r=12 t=3 e=0", rsp0_valid, rsp0_result, rsp0_tag, rsp0_err);
    end
    step();
    tests++;
    if (rsp0_valid !== 1'b0) begin
      fails++; $display("FAIL single_drain: got v=%b want 0", rsp0_valid);
    end
  endtask

  task automatic test_contention();
    idle_inputs();
    rst_n = 0; #2; rst_n = 1;
    step();
    req0_valid = 1; req0_op = 4'b0000; req0_a = 1; req0_b = 2; req0_tag = 1;
    req1_valid = 1; req1_op = 4'b1000; req1_a = 5; req1_b = 7; req1_tag = 2;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
        fails++; $display("FAIL contention_grant%0d: got %b%b want %b%b", i, req0_ready, req1_ready, (i % 2 == 0), (i % 2 == 1));
      end
      step();
      tests++;
      if (i % 2 == 0) begin
        if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd3 || rsp0_tag !== 4'd1) begin
          fails++; $display("FAIL contention_rsp0_%0d: got v=%b r=%h t=%0d want v=1 r=3 t=1", i, rsp0_valid, rsp0_result, rsp0_tag);
        end
      end else begin
        if (rsp1_valid !== 1'b1 || rsp1_result !== 32'hFFFFFFFE || rsp1_tag !== 4'd2 || rsp1_err !== 1'b0) begin
          fails++; $display("FAIL contention_rsp1_%0d: got v=%b r=%h t=%0d want v=1 r=fffffffe t=2", i, rsp1_valid, rsp1_result, rsp1_tag);
        end
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_backpressure();
    idle_inputs();
    req0_valid = 1; req0_op = 4'b0000; req0_a = 10; req0_b = 20; req0_tag = 5;
    rsp0_ready = 0;
    step();
    req0_op = 4'b0100; req0_a = 32'hFF; req0_b = 32'h0F; req0_tag = 6;
    req1_valid = 1; req1_op = 4'b0000; req1_b = 1;
    for (int j = 0; j < 3; j++) begin
      req1_a = 32'(j); req1_tag = 4'(j + 8);
      #1;
      tests++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
        fails++; $display("FAIL bp_grant%0d: got %b%b want 01", j, req0_ready, req1_ready);
      end
      step();
      tests++;
      if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd30 || rsp0_tag !== 4'd5 || rsp0_err !== 1'b0) begin
        fails++; $display("FAIL bp_hold%0d: got v=%b r=%0d t=%0d want v=1 r=30 t=5", j, rsp0_valid, rsp0_result, rsp0_tag);
      end
      tests++;
      if (rsp1_valid !== 1'b1 || rsp1_result !== 32'(j + 1) || rsp1_tag !== 4'(j + 8)) begin
        fails++; $display("FAIL bp_rsp1_%0d: got v=%b r=%0d t=%0d want v=1 r=%0d t=%0d", j, rsp1_valid, rsp1_result, rsp1_tag, j + 1, j + 8);
      end
    end
    rsp0_ready = 1;
    #1;
    tests++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      fails++; $display("FAIL bp_release_grant: got %b%b want 10", req0_ready, req1_ready);
    end
    step();
    tests++;
    if (rsp0_valid !== 1'b1 || rsp0_result !== 32'hF0 || rsp0_tag !== 4'd6) begin
      fails++; $display("FAIL bp_release_rsp: got v=%b r=%h t=%0d want v=1 r=f0 t=6", rsp0_valid, rsp0_result, rsp0_tag);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [11];
    logic [31:0] as  [11];
    logic [31:0] bs  [11];
    logic [31:0] exp [11];
    logic        errs[11];
    ops = '{4'b0010, 4'b0011, 4'b1101, 4'b0001, 4'b0101, 4'b0100, 4'b0110, 4'b0111, 4'b0000, 4'b1010, 4'b0000};
    as  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h1, 32'h80000000, 32'hF0F0, 32'h0F, 32'hFF, 32'hFFFFFFFF, 32'h5, 32'h1};
    bs  = '{32'h1, 32'h1, 32'd33, 32'd4, 32'd31, 32'hFF00, 32'hF0, 32'h3C, 32'h2, 32'h5, 32'h1};
    exp = '{32'h1, 32'h0, 32'hC0000000, 32'h10, 32'h1, 32'h0FF0, 32'hFF, 32'h3C, 32'h1, 32'h0, 32'h2};
    errs = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    idle_inputs();
    req0_valid = 1;
    for (int k = 0; k < 11; k++) begin
      req0_op = ops[k]; req0_a = as[k]; req0_b = bs[k];
      req0_tag = (k == 9) ? 4'd9 : 4'(k);
      step();
      tests++;
      if (rsp0_valid !== 1'b1 || rsp0_result !== exp[k] || rsp0_err !== errs[k] || rsp0_tag !== req0_tag) begin
        fails++; $display("FAIL op%0d_%b: got v=%b r=%h e=%b t=%0d want v=1 r=%h e=%b t=%0d",
                          k, ops[k], rsp0_valid, rsp0_result, rsp0_err, rsp0_tag, exp[k], errs[k], req0_tag);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    req0_valid = 1; req0_op = 4'b0000; req0_a = 2; req0_b = 3; req0_tag = 4;
    rsp0_ready = 0;
    step();
    req0_valid = 0;
    tests++;
    if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd5) begin
      fails++; $display("FAIL midrst_fill: got v=%b r=%0d want v=1 r=5", rsp0_valid, rsp0_result);
    end
    rst_n = 0;
    #1;
    tests++;
    if (rsp0_valid !== 1'b0 || rsp0_result !== 32'h0 || rsp0_tag !== 4'h0) begin
      fails++; $display("FAIL midrst_async: got v=%b r=%h t=%0d want 0", rsp0_valid, rsp0_result, rsp0_tag);
    end
    step();
    rst_n = 1;
    rsp0_ready = 1;
    for (int c = 0; c < 2; c++) begin
      step();
      tests++;
      if (rsp0_valid !== 1'b0) begin
        fails++; $display("FAIL midrst_noresp%0d: got v=%b want 0", c, rsp0_valid);
      end
    end
    req0_valid = 1; req1_valid = 1;
    #1;
    tests++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      fails++; $display("FAIL midrst_ptr: got %b%b want 10", req0_ready, req1_ready);
    end
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
